// File: rtl/dma_responder_if.sv
// DMA handshake bundle between the DELQA core (initiator) and the DMA responder (target).
// The initiator drives the request/strobe side; the target answers with grant, ack and read data.
interface dma_responder_if;
  logic        dma_req;   // initiator wants the bus
  logic        dma_gnt;   // target has granted the bus
  logic [21:0] dma_adr;   // byte address, bit 0 ignored
  logic [15:0] dma_wdat;  // initiator -> memory data
  logic [15:0] dma_rdat;  // memory -> initiator data, valid with dma_ack
  logic        dma_stb;   // transfer strobe, held until ack seen
  logic        dma_we;    // 1 = write to memory
  logic        dma_ack;   // transfer acknowledge, held until strobe falls

  modport master (
    output dma_req, dma_adr, dma_wdat, dma_stb, dma_we,
    input  dma_gnt, dma_rdat, dma_ack
  );

  modport slave (
    input  dma_req, dma_adr, dma_wdat, dma_stb, dma_we,
    output dma_gnt, dma_rdat, dma_ack
  );
endinterface

// File: rtl/dma_responder.sv
// DMA responder: grants the DELQA core the memory bus, holds the host CPU off while
// granted, turns each DMA strobe into one wishbone cycle and returns ack plus read data.
// A memory that never answers is timed out and reported with a one-clock NXM pulse.
// After BURST transfers the grant is yielded for a while if the host wants the bus.
module dma_responder #(
  parameter int unsigned TIMEOUT   = 63,
  parameter int unsigned BURST     = 8,
  parameter int unsigned YIELD_CYC = 4
) (
  input  logic           wb_clkp_i,
  input  logic           wb_rst_i,
  dma_responder_if.slave dma,
  input  logic           hst_cyc_i,
  input  logic           hst_req_i,
  output logic           hold_o,
  output logic [21:0]    mem_adr_o,
  output logic [15:0]    mem_dat_o,
  input  logic [15:0]    mem_dat_i,
  output logic           mem_cyc_o,
  output logic           mem_stb_o,
  output logic           mem_we_o,
  output logic [1:0]     mem_sel_o,
  input  logic           mem_ack_i,
  output logic           nxm_o
);

  localparam logic [7:0] TIMEOUT_C    = 8'(TIMEOUT);
  localparam logic [7:0] BURST_C      = 8'(BURST);
  localparam logic [7:0] YIELD_LAST_C = 8'(YIELD_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_MEM   = 3'd2,
    ST_ACK   = 3'd3,
    ST_YIELD = 3'd4
  } state_e;

  // Saturating 8-bit increment for the burst counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        mem_cyc_q, mem_cyc_d;
  logic        mem_we_q, mem_we_d;
  logic [1:0]  sel_q, sel_d;
  logic [21:0] adr_q, adr_d;
  logic [15:0] wdat_q, wdat_d;
  logic [15:0] rdat_q, rdat_d;
  logic        ack_q, ack_d;
  logic        nxm_q, nxm_d;
  logic [7:0]  timer_q, timer_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  ycnt_q, ycnt_d;

  logic        in_mem_s;
  logic        mem_done_s;
  logic        mem_tmo_s;
  logic        stb_drop_s;
  logic [7:0]  cnt_inc_s;
  logic        adr_bit0_unused_s;

  // Word transfers: the byte-select address bit carries no information.
  assign adr_bit0_unused_s = dma.dma_adr[0];

  assign in_mem_s   = (state_q == ST_MEM);
  // A memory ack arriving on the timeout clock still wins over NXM.
  assign mem_done_s = in_mem_s & mem_ack_i;
  assign mem_tmo_s  = in_mem_s & ~mem_ack_i & (timer_q == TIMEOUT_C);
  assign stb_drop_s = (state_q == ST_ACK) & ~dma.dma_stb;
  assign cnt_inc_s  = sat_inc8(cnt_q);

  // FSM state register.
  always_ff @(posedge wb_clkp_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (dma.dma_req & ~hst_cyc_i) begin
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (dma.dma_stb) begin
          state_d = ST_MEM;
        end else if (~dma.dma_req) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GRANT;
        end
      end
      ST_MEM: begin
        if (mem_done_s | mem_tmo_s) begin
          state_d = ST_ACK;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_ACK: begin
        if (stb_drop_s) begin
          if ((cnt_inc_s == BURST_C) & hst_req_i) begin
            state_d = ST_YIELD;
          end else begin
            state_d = ST_GRANT;
          end
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_YIELD: begin
        if (ycnt_q == YIELD_LAST_C) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_YIELD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; every output is registered from these.
  always_comb begin
    gnt_d     = (state_d == ST_GRANT) | (state_d == ST_MEM) | (state_d == ST_ACK);
    mem_cyc_d = (state_d == ST_MEM);
    sel_d     = mem_cyc_d ? 2'b11 : 2'b00;
    ack_d     = (state_d == ST_ACK);
    nxm_d     = mem_tmo_s;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    mem_we_d  = 1'b0;
    rdat_d    = 16'h0000;
    timer_d   = 8'd0;
    cnt_d     = cnt_q;
    ycnt_d    = 8'd0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
      end
      ST_GRANT: begin
        if (dma.dma_stb) begin
          adr_d    = {dma.dma_adr[21:1], 1'b0};
          wdat_d   = dma.dma_wdat;
          mem_we_d = dma.dma_we;
        end else begin
          mem_we_d = 1'b0;
        end
      end
      ST_MEM: begin
        if (mem_done_s) begin
          rdat_d = mem_we_q ? 16'h0000 : mem_dat_i;
        end else if (mem_tmo_s) begin
          rdat_d = 16'h0000;
        end else begin
          mem_we_d = mem_we_q;
          timer_d  = timer_q + 8'd1;
        end
      end
      ST_ACK: begin
        if (stb_drop_s) begin
          cnt_d = cnt_inc_s;
        end else begin
          rdat_d = rdat_q;
        end
      end
      ST_YIELD: begin
        ycnt_d = ycnt_q + 8'd1;
      end
      default: begin
        cnt_d = 8'd0;
      end
    endcase
  end

  // Output and datapath registers; reset abandons any memory cycle at the next edge.
  always_ff @(posedge wb_clkp_i) begin
    if (wb_rst_i) begin
      gnt_q     <= 1'b0;
      mem_cyc_q <= 1'b0;
      mem_we_q  <= 1'b0;
      sel_q     <= 2'b00;
      adr_q     <= 22'd0;
      wdat_q    <= 16'h0000;
      rdat_q    <= 16'h0000;
      ack_q     <= 1'b0;
      nxm_q     <= 1'b0;
      timer_q   <= 8'd0;
      cnt_q     <= 8'd0;
      ycnt_q    <= 8'd0;
    end else begin
      gnt_q     <= gnt_d;
      mem_cyc_q <= mem_cyc_d;
      mem_we_q  <= mem_we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      rdat_q    <= rdat_d;
      ack_q     <= ack_d;
      nxm_q     <= nxm_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      ycnt_q    <= ycnt_d;
    end
  end

  assign dma.dma_gnt  = gnt_q;
  assign dma.dma_ack  = ack_q;
  assign dma.dma_rdat = rdat_q;
  assign hold_o       = gnt_q;
  assign mem_adr_o    = adr_q;
  assign mem_dat_o    = wdat_q;
  assign mem_cyc_o    = mem_cyc_q;
  assign mem_stb_o    = mem_cyc_q;
  assign mem_we_o     = mem_we_q;
  assign mem_sel_o    = sel_q;
  assign nxm_o        = nxm_q;

endmodule
